// File: rtl/rf_writeback_ctrl.sv
// Register-file writeback controller: buffers EX/MEM write requests in a FIFO and drains one per cycle.
// Optional bypass lookup for readers SA/SB is built when RF_WB_FWD_EN is defined.
module rf_writeback_ctrl #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ex_valid,
    output logic                     ex_ready,
    input  logic [AW-1:0]            ex_reg,
    input  logic [DW-1:0]            ex_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [AW-1:0]            mem_reg,
    input  logic [DW-1:0]            mem_data,
    input  logic                     hold,
    output logic                     rf_ld,
    output logic [AW-1:0]            rf_c,
    output logic [DW-1:0]            rf_pw,
    output logic                     pc_wr,
    input  logic [AW-1:0]            SA,
    input  logic [AW-1:0]            SB,
    output logic                     fwd_a_hit,
    output logic [DW-1:0]            fwd_a_data,
    output logic                     fwd_b_hit,
    output logic [DW-1:0]            fwd_b_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] reg_q [DEPTH];
    logic [DW-1:0] dat_q [DEPTH];
    logic [PW-1:0] head, tail;

    logic          mem_fire, ex_fire, push, pop;
    logic [AW-1:0] push_reg;
    logic [DW-1:0] push_data;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // MEM is the older instruction, so it wins; ready comes from registered full only
    assign mem_ready = !full;
    assign ex_ready  = !full && !mem_valid;
    assign mem_fire  = mem_valid && mem_ready;
    assign ex_fire   = ex_valid && ex_ready;
    assign push      = mem_fire || ex_fire;
    assign pop       = !empty && !hold;
    assign push_reg  = mem_fire ? mem_reg  : ex_reg;
    assign push_data = mem_fire ? mem_data : ex_data;

    // FIFO storage: data only, pointers carry validity
    always_ff @(posedge CLK) begin
        if (push) begin
            reg_q[tail] <= push_reg;
            dat_q[tail] <= push_data;
        end
    end

    // Pointers, occupancy and the registered write port
    always_ff @(posedge CLK) begin
        if (RST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            rf_ld <= 1'b0;
            pc_wr <= 1'b0;
            rf_c  <= '0;
            rf_pw <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop) begin
                rf_ld <= 1'b1;
                rf_c  <= reg_q[head];
                rf_pw <= dat_q[head];
                pc_wr <= (reg_q[head] == AW'(15));
                head  <= head + 1'b1;
            end else begin
                rf_ld <= 1'b0;
                pc_wr <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef RF_WB_FWD_EN
    // Scan oldest to youngest so the youngest match overrides; the output register is oldest of all
    function automatic logic [DW:0] fwd_lookup(input logic [AW-1:0] sel);
        logic [DW:0]   r;
        logic [PW-1:0] idx;
        r = '0;
        if (rf_ld && (rf_c == sel))
            r = {1'b1, rf_pw};
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (reg_q[idx] == sel))
                r = {1'b1, dat_q[idx]};
        end
        return r;
    endfunction

    always_comb begin
        {fwd_a_hit, fwd_a_data} = fwd_lookup(SA);
        {fwd_b_hit, fwd_b_data} = fwd_lookup(SB);
    end
`else
    logic unused_sel;
    assign unused_sel = ^{SA, SB};
    assign fwd_a_hit  = 1'b0;
    assign fwd_a_data = '0;
    assign fwd_b_hit  = 1'b0;
    assign fwd_b_data = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed self-checking bench for rf_writeback_ctrl (default DEPTH=4, DW=32, AW=4).
module tb_rf_writeback_ctrl;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ex_valid, ex_ready, mem_valid, mem_ready, hold;
    logic [AW-1:0] ex_reg, mem_reg, rf_c, SA, SB;
    logic [DW-1:0] ex_data, mem_data, rf_pw, fwd_a_data, fwd_b_data;
    logic          rf_ld, pc_wr, fwd_a_hit, fwd_b_hit, full, empty;
    logic [$clog2(DEPTH):0] count;

    int n_tests = 0;
    int n_fail  = 0;

    rf_writeback_ctrl #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .CLK(CLK), .RST(RST),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_reg(ex_reg), .ex_data(ex_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .hold(hold), .rf_ld(rf_ld), .rf_c(rf_c), .rf_pw(rf_pw), .pc_wr(pc_wr),
        .SA(SA), .SB(SB),
        .fwd_a_hit(fwd_a_hit), .fwd_a_data(fwd_a_data),
        .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data),
        .count(count), .full(full), .empty(empty)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; hold = 1'b0;
        ex_valid = 1'b0; ex_reg = '0; ex_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        SA = '0; SB = '0;
        tick(); tick();
        RST = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_rf_ld", 32'(rf_ld), 32'd0);
        chk("rst_rf_c",  32'(rf_c),  32'd0);
        chk("rst_rf_pw", rf_pw,      32'd0);

        // Reset mid-drain: three back-to-back pushes while draining
        for (int i = 0; i < 3; i++) begin
            ex_valid = 1'b1; ex_reg = AW'(1 + i); ex_data = 32'h10 + 32'(i);
            tick();
        end
        ex_valid = 1'b0;
        chk("md_count", 32'(count), 32'd1);
        chk("md_rf_ld", 32'(rf_ld), 32'd1);
        chk("md_rf_c",  32'(rf_c),  32'd2);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("md_rst_count", 32'(count), 32'd0);
        chk("md_rst_empty", 32'(empty), 32'd1);
        chk("md_rst_rf_ld", 32'(rf_ld), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("md_no_write", 32'(rf_ld), 32'd0);
        end

        // Single write
        ex_valid = 1'b1; ex_reg = 4'd5; ex_data = 32'h0000_00AA;
        #1 chk("sw_ex_ready", 32'(ex_ready), 32'd1);
        tick();
        ex_valid = 1'b0;
        chk("sw_latency_ld", 32'(rf_ld), 32'd0);
        chk("sw_count1",     32'(count), 32'd1);
        tick();
        chk("sw_rf_ld", 32'(rf_ld), 32'd1);
        chk("sw_rf_c",  32'(rf_c),  32'd5);
        chk("sw_rf_pw", rf_pw,      32'h0000_00AA);
        chk("sw_pc_wr", 32'(pc_wr), 32'd0);
        tick();
        chk("sw_ld_once", 32'(rf_ld), 32'd0);
        chk("sw_c_holds", 32'(rf_c),  32'd5);

        // Arbitration: MEM wins, EX follows next cycle
        mem_valid = 1'b1; mem_reg = 4'd2; mem_data = 32'h22;
        ex_valid  = 1'b1; ex_reg  = 4'd3; ex_data  = 32'h33;
        #1;
        chk("arb_mem_ready", 32'(mem_ready), 32'd1);
        chk("arb_ex_ready",  32'(ex_ready),  32'd0);
        tick();
        mem_valid = 1'b0;
        #1 chk("arb_ex_ready2", 32'(ex_ready), 32'd1);
        tick();
        ex_valid = 1'b0;
        chk("arb_first_c",  32'(rf_c),  32'd2);
        chk("arb_first_pw", rf_pw,      32'h22);
        tick();
        chk("arb_second_ld", 32'(rf_ld), 32'd1);
        chk("arb_second_c",  32'(rf_c),  32'd3);
        chk("arb_second_pw", rf_pw,      32'h33);
        tick();
        chk("arb_done_ld",    32'(rf_ld), 32'd0);
        chk("arb_done_empty", 32'(empty), 32'd1);

        // Full under hold, rejected push, then in-order drain
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ex_valid = 1'b1; ex_reg = AW'(8 + i); ex_data = 32'h80 + 32'(i);
            tick();
            chk("fh_held_ld", 32'(rf_ld), 32'd0);
        end
        ex_valid = 1'b0;
        chk("fh_full",  32'(full),  32'd1);
        chk("fh_count", 32'(count), 32'd4);
        mem_valid = 1'b1; mem_reg = 4'd12; mem_data = 32'hDEAD;
        #1;
        chk("fh_mem_ready", 32'(mem_ready), 32'd0);
        chk("fh_ex_ready",  32'(ex_ready),  32'd0);
        hold = 1'b0;
        tick();
        mem_valid = 1'b0;
        chk("fh_pop_no_push_count", 32'(count), 32'd3);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            chk("fh_drain_ld", 32'(rf_ld), 32'd1);
            chk("fh_drain_c",  32'(rf_c),  32'(8 + i));
            chk("fh_drain_pw", rf_pw,      32'h80 + 32'(i));
        end
        tick();
        chk("fh_after_ld",    32'(rf_ld), 32'd0);
        chk("fh_after_empty", 32'(empty), 32'd1);

        // PC write
        mem_valid = 1'b1; mem_reg = 4'd15; mem_data = 32'h100;
        tick();
        mem_valid = 1'b0;
        tick();
        chk("pc_rf_ld", 32'(rf_ld), 32'd1);
        chk("pc_pc_wr", 32'(pc_wr), 32'd1);
        chk("pc_rf_c",  32'(rf_c),  32'd15);
        chk("pc_rf_pw", rf_pw,      32'h100);
        tick();
        chk("pc_wr_drop", 32'(pc_wr), 32'd0);

        // Bypass lookup
        hold = 1'b1;
        ex_valid = 1'b1; ex_reg = 4'd7; ex_data = 32'h11;
        tick();
        ex_data = 32'h22;
        tick();
        ex_valid = 1'b0;
        SA = 4'd7; SB = 4'd8;
        #1;
`ifdef RF_WB_FWD_EN
        chk("fwd_a_hit",  32'(fwd_a_hit),  32'd1);
        chk("fwd_a_data", fwd_a_data,      32'h22);
`else
        chk("fwd_a_hit",  32'(fwd_a_hit),  32'd0);
        chk("fwd_a_data", fwd_a_data,      32'd0);
`endif
        chk("fwd_b_hit",  32'(fwd_b_hit),  32'd0);
        chk("fwd_b_data", fwd_b_data,      32'd0);
        hold = 1'b0;
        tick();
        tick();
        // Only the output register holds r7 now
`ifdef RF_WB_FWD_EN
        chk("fwd_outreg_hit",  32'(fwd_a_hit), 32'd1);
        chk("fwd_outreg_data", fwd_a_data,     32'h22);
`else
        chk("fwd_outreg_hit",  32'(fwd_a_hit), 32'd0);
        chk("fwd_outreg_data", fwd_a_data,     32'd0);
`endif
        tick();
        chk("fwd_gone_hit", 32'(fwd_a_hit), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/rf_writeback_ctrl.md
Name: rf_writeback_ctrl

Overview:
- Writer-side controller for the 16-entry register file. Collects destination-register write requests from the EX and MEM pipeline stages and buffers them in a small FIFO.
- Drains the FIFO one entry per cycle onto the register-file write port (C, PW, RFLd). Flags writes to R15 so the PC mux selects PW over PCin.
- Optionally exposes a bypass lookup so readers (SA/SB) see pending data before it lands in the register file.

Parameters:
DEPTH, 4, FIFO entries (power of 2, min 2)
DW, 32, data width
AW, 4, register index width

Ports:
CLK  in  1  clock, rising-edge
RST  in  1  reset
ex_valid  in  1  EX write request valid
ex_ready  out  1  EX request accepted this cycle
ex_reg  in  AW  EX destination register
ex_data  in  DW  EX result
mem_valid  in  1  MEM write request valid
mem_ready  out  1  MEM request accepted this cycle
mem_reg  in  AW  MEM destination register
mem_data  in  DW  MEM load result
hold  in  1  freeze drain (pipeline stall)
rf_ld  out  1  register-file write enable (RFLd)
rf_c  out  AW  register-file write select (C)
rf_pw  out  DW  register-file write data (PW)
pc_wr  out  1  high with rf_ld when rf_c==15
SA  in  AW  read select A, bypass lookup
SB  in  AW  read select B, bypass lookup
fwd_a_hit  out  1  pending write to SA exists
fwd_a_data  out  DW  youngest pending data for SA
fwd_b_hit  out  1  pending write to SB exists
fwd_b_data  out  DW  youngest pending data for SB
count  out  clog2(DEPTH)+1  FIFO occupancy
full  out  1  count==DEPTH
empty  out  1  count==0

Behaviour:
- Reset: RST is synchronous, active-high. On a CLK edge with RST=1:
  - pointers and count go to 0;
  - rf_ld, pc_wr, rf_c and rf_pw go to 0;
  - all pending entries are discarded, including mid-drain;
  - RST overrides push, pop and hold.
- Arbitration: one push per cycle. MEM has priority as the older instruction.
  - mem_ready = !full.
  - ex_ready = !full && !mem_valid.
  - A handshake completes when valid && ready at the rising edge.
- Push: {reg, data} is written at the tail, tail pointer increments mod DEPTH, count+1.
- Full: no push even if a pop occurs the same edge. ready is based on registered full only, with no combinational path from pop.
- Pop: at an edge where !empty && !hold, the head moves into the output register:
  - rf_ld<=1, rf_c<=head.reg, rf_pw<=head.data;
  - pc_wr<=(head.reg==15);
  - head increments, count-1.
- Otherwise at that edge rf_ld<=0 and pc_wr<=0. rf_c and rf_pw hold their last values.
- Outputs are registered. rf_ld is high for exactly one cycle per popped entry.
- Latency: push at edge N into an empty FIFO gives pop at edge N+1. rf_ld is high during cycle N+1..N+2, and the register file captures at edge N+2.
- Simultaneous push+pop (not full): count unchanged, both pointers advance.
- Hold: count can grow to full while held. When hold drops, draining resumes on the next edge.
- Write ordering: entries drain in acceptance order. Two writes to the same register land in order.
- Bypass lookup (combinational):
  - Priority is youngest first: FIFO entries tail-1 back to head, then the output register when rf_ld=1.
  - hit=0 and data=0 when nothing matches.
  - A match on register 15 is reported like any other register.

Optional Feature:
- Macro RF_WB_FWD_EN.
- Defined: the bypass lookup is built as described in Behaviour.
- Undefined: fwd_a_hit, fwd_b_hit, fwd_a_data and fwd_b_data are tied to 0, the SA/SB inputs are unused, and no compare logic is generated.
- All other behaviour is identical in both builds.

Test Plan:
- Reset mid-drain: push 3 entries, assert RST at the next edge -> count=0, empty=1, rf_ld=0 in the following cycle; no further writes appear.
- Single write: EX pushes (reg 5, 0x0000_00AA) at edge N -> rf_ld=1, rf_c=5, rf_pw=0xAA for exactly cycle N+1..N+2, pc_wr=0.
- Arbitration: mem_valid and ex_valid both high with regs 2 and 3 -> mem_ready=1, ex_ready=0; reg 2 drains first, and EX is accepted on the next cycle.
- Full/hold: hold=1, push 4 entries -> full=1, ex_ready=0 and mem_ready=0. Release hold -> 4 consecutive rf_ld pulses in FIFO order, then empty=1.
- PC write: push (reg 15, 0x100) -> pc_wr=1 coincident with rf_ld, rf_c=15, rf_pw=0x100.
- Bypass (RF_WB_FWD_EN): hold=1, push (r7, 0x11) then (r7, 0x22), SA=7 -> fwd_a_hit=1, fwd_a_data=0x22. Set SB=8 -> fwd_b_hit=0, fwd_b_data=0.
